// File: rtl/mdac_pkg.sv
// Shared definitions for the access-code lock: state encodings, digit width
// and the one-hot button decode used by both the controller and the conditioning logic.
package mdac_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 2;

    typedef enum logic [STATE_W-1:0] {
        st_locked  = 3'd0,
        st_entry   = 3'd1,
        st_check   = 3'd2,
        st_open    = 3'd3,
        st_err     = 3'd4,
        st_lockout = 3'd5
    } state_t;

    function automatic logic btn_is_onehot(input logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [DIGIT_W-1:0] btn_to_digit(input logic [3:0] b);
        case (b)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdac_timer.sv
// Loadable down-counter shared by the OPEN, ERR and LOCKOUT phases.
// done is high whenever the count has reached zero.
module mdac_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mdac_ctrl.sv
// Access-code lock sequencer: buffers digit pulses, checks them against SECRET
// on enter, and runs the timed unlock / error / lockout phases.
module mdac_ctrl
    import mdac_pkg::*;
#(
    parameter int                      CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   SECRET         = 8'b10_00_11_01,
    parameter int                      MAX_TRIES      = 3,
    parameter int                      UNLOCK_CYCLES  = 500,
    parameter int                      ERR_CYCLES     = 100,
    parameter int                      LOCKOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn,
    input  logic               enter,
    input  logic               clear,
    output logic               locked,
    output logic               unlocked,
    output logic               error,
    output logic [STATE_W-1:0] state
);

    localparam int BUF_W   = DIGIT_W * CODE_LEN;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int MAX_CYC = (UNLOCK_CYCLES > ERR_CYCLES)
                           ? ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES)
                           : ((ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The timer is loaded with N-1 so the phase lasts exactly N cycles.
    localparam logic [TW-1:0]    LD_OPEN    = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]    LD_ERR     = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0]    LD_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(CODE_LEN);
    localparam logic [2:0]       TRIES_MAX  = 3'(MAX_TRIES);

    state_t             state_r, state_next;
    logic [BUF_W-1:0]   buffer;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [2:0]         tries;

    logic               btn_valid;
    logic [DIGIT_W-1:0] digit;
    logic               shift_en, ovf_set, clr_entry, tries_inc, tries_clr;
    logic               tmr_load, tmr_done;
    logic [TW-1:0]      tmr_value;
    logic               code_match;

    assign btn_valid  = btn_is_onehot(btn);
    assign digit      = btn_to_digit(btn);
    assign code_match = (count == FULL) && !overflow && (buffer == SECRET);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_next = state_r;
        shift_en   = 1'b0;
        ovf_set    = 1'b0;
        clr_entry  = 1'b0;
        tries_inc  = 1'b0;
        tries_clr  = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        case (state_r)
            st_locked: begin
                if (!clear && !enter && btn_valid) begin
                    shift_en   = 1'b1;
                    state_next = st_entry;
                end
            end
            st_entry: begin
                if (clear) begin
                    clr_entry  = 1'b1;
                    state_next = st_locked;
                end else if (enter) begin
                    state_next = st_check;
                end else if (btn_valid) begin
                    if (count == FULL) ovf_set  = 1'b1;
                    else               shift_en = 1'b1;
                end
            end
            st_check: begin
                clr_entry = 1'b1;
                tmr_load  = 1'b1;
                if (code_match) begin
                    tries_clr  = 1'b1;
                    tmr_value  = LD_OPEN;
                    state_next = st_open;
                end else if (tries + 3'd1 == TRIES_MAX) begin
                    tries_inc  = 1'b1;
                    tmr_value  = LD_LOCKOUT;
                    state_next = st_lockout;
                end else begin
                    tries_inc  = 1'b1;
                    tmr_value  = LD_ERR;
                    state_next = st_err;
                end
            end
            st_open: begin
                if (clear || tmr_done) state_next = st_locked;
            end
            st_err: begin
                if (tmr_done) state_next = st_locked;
            end
            st_lockout: begin
                if (tmr_done) begin
                    tries_clr  = 1'b1;
                    state_next = st_locked;
                end
            end
            default: state_next = st_locked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= st_locked;
            buffer   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tries    <= '0;
        end else begin
            state_r <= state_next;
            if (clr_entry) begin
                buffer   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (shift_en) begin
                    buffer <= (buffer << DIGIT_W) | BUF_W'(digit);
                    count  <= count + CNT_W'(1);
                end
                if (ovf_set) overflow <= 1'b1;
            end
            if (tries_clr)      tries <= '0;
            else if (tries_inc) tries <= tries + 3'd1;
        end
    end

    mdac_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    assign state    = state_r;
    assign unlocked = (state_r == st_open);
    assign locked   = (state_r != st_open);
    assign error    = (state_r == st_err) || (state_r == st_lockout);

endmodule

// File: doc/mdac_ctrl.md
# mdac_ctrl

Sequencing controller for the multi-digit access-code lock. It accepts single-cycle button pulses, buffers the entered digits and compares them against a parameterised secret on `enter`. It drives the lock/unlock/error outputs with timed unlock, error and lockout phases. It sits directly under `mdac_top`, behind the button conditioning logic, and owns all of the lock's state.

## Interface
Parameters:
- `CODE_LEN`, 4: number of digits in the code (1..8).
- `SECRET`, 8'b10_00_11_01: code as 2-bit digits; first-entered digit is in the MSBs; width 2*CODE_LEN.
- `MAX_TRIES`, 3: consecutive failed checks that trigger lockout (1..7).
- `UNLOCK_CYCLES`, 500: cycles spent in OPEN.
- `ERR_CYCLES`, 100: cycles spent in ERR.
- `LOCKOUT_CYCLES`, 1000: cycles spent in LOCKOUT.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `btn` in 4: one-hot digit pulse, already debounced, 1 cycle wide. Bit i means digit i.
- `enter` in 1: submit pulse.
- `clear` in 1: abort/relock pulse.
- `locked` out 1: high in every state except OPEN.
- `unlocked` out 1: high only in OPEN.
- `error` out 1: high in ERR and LOCKOUT.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: LOCKED=0, ENTRY=1, CHECK=2, OPEN=3, ERR=4, LOCKOUT=5. Encodings 6 and 7 are illegal and go to LOCKED on the next cycle.
- Input priority when inputs coincide: `clear` > `enter` > `btn`.
- `btn` decoding:
  - Valid only when exactly one bit is set; any other value is ignored.
  - Valid digits are accepted only in LOCKED and ENTRY.
  - Accepted digit: shifted into the buffer, digit counter incremented; LOCKED → ENTRY.
  - Once the counter is at CODE_LEN, further digits set a sticky `overflow` flag and the buffer stops changing.
- `enter`:
  - In ENTRY: → CHECK.
  - In LOCKED (zero digits entered): ignored.
  - In all other states: ignored.
- CHECK, one cycle:
  - Match requires count==CODE_LEN, !overflow and buffer==SECRET.
  - Match: → OPEN, try counter cleared.
  - Mismatch: try counter incremented. If the new value equals MAX_TRIES → LOCKOUT, otherwise → ERR.
  - Buffer, count and overflow are cleared on leaving CHECK.
- `clear`:
  - In ENTRY: clears buffer, count and overflow; → LOCKED.
  - In OPEN: → LOCKED immediately (manual relock).
  - Ignored in ERR, LOCKOUT and CHECK.
- Timed states:
  - OPEN, ERR and LOCKOUT each load the timer on entry.
  - On expiry, each returns to LOCKED.
  - LOCKOUT expiry also clears the try counter.
- Try counter: 3 bits, never exceeds MAX_TRIES.
- Reset values: state=LOCKED, buffer, count, overflow, tries and timer all 0; locked=1, unlocked=0, error=0, state=3'b000.

## Timing
- Outputs are decoded from the state register: no combinational path from inputs to outputs.
- `btn` pulse at cycle t: digit is in the buffer at t+1; state reads ENTRY at t+1.
- `enter` at cycle t: state=CHECK at t+1; OPEN, ERR or LOCKOUT at t+2.
- Timed-state duration: state holds for exactly N cycles (UNLOCK_CYCLES, ERR_CYCLES or LOCKOUT_CYCLES), then reads LOCKED on cycle N+1.
- `clear` at t: LOCKED at t+1.
- Reset asserted in any state, including mid-timer: LOCKED on the next edge. Tries are lost.

## Structure
- Shared package `mdac_pkg` holds:
  - state encodings and the `STATE_W`=3 constant;
  - `DIGIT_W`=2;
  - the one-hot-to-digit decode function, shared with the conditioning logic.
- Sub-module `mdac_timer`: loadable down-counter with a `load` input, a value input and a `done` output. Width is `$clog2` of the largest cycle parameter. One instance is shared by OPEN, ERR and LOCKOUT.

## Test plan
Bench parameters: SECRET=2,0,3,1; UNLOCK_CYCLES=8; ERR_CYCLES=4; LOCKOUT_CYCLES=16; MAX_TRIES=3.
- Correct code: btn 0100, 0001, 1000, 0010, then enter. Required: CHECK one cycle later, then `unlocked`=1 for exactly 8 cycles, then LOCKED with locked=1.
- Wrong code: 2,0,3,0 + enter. Required: error=1 for 4 cycles, then LOCKED; tries=1.
- Lockout: three wrong codes. Required: third goes to LOCKOUT (`state`=5), error=1 for 16 cycles; correct code entered during LOCKOUT is ignored; LOCKED afterwards with tries=0.
- Malformed input:
  - 5 digits (2,0,3,1,1) + enter → ERR (overflow).
  - btn=0110 is ignored.
  - enter in LOCKED with no digits → no state change.
- Priority and abort:
  - clear+enter in the same cycle in ENTRY → LOCKED with buffer cleared.
  - clear in OPEN at timer cycle 3 → LOCKED next cycle.
  - reset at LOCKOUT cycle 5 → LOCKED next edge, all outputs at reset values.
